ahbl_arb2: RTL and testbench
============================

AHBL_ARB2 -- requirements
Module: ahbl_arb2

Interface
REQ-001 SHALL have parameter DEFAULT_MASTER, default 0, meaning the master that owns the idle bus after reset and wins the first contested arbitration.
REQ-002 SHALL have port HCLK  input  1  the single clock for all state.
REQ-003 SHALL have port HRESET  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port Mx_HADDR (x=0,1)  input  32  master x address.
REQ-005 SHALL have port Mx_HTRANS, Mx_HSIZE, Mx_HBURST, Mx_HPROT  input  2/3/3/4  master x control.
REQ-006 SHALL have port Mx_HWRITE, Mx_HMASTLOCK  input  1/1  master x direction and lock.
REQ-007 SHALL have port Mx_HWDATA  input  32  master x write data.
REQ-008 SHALL have port Mx_HRDATA  output  32  read data to master x, equal to S_HRDATA.
REQ-009 SHALL have port Mx_HREADY, Mx_HRESP  output  1/1  ready and response to master x.
REQ-010 SHALL have port S_HADDR, S_HTRANS, S_HSIZE, S_HBURST, S_HPROT, S_HWRITE, S_HMASTLOCK, S_HWDATA  output  32/2/3/3/4/1/1/32  shared AHB-Lite bus to the slave (e.g. CoreSDR_AHB).
REQ-011 SHALL have port S_HRDATA, S_HREADY, S_HRESP  input  32/1/1  slave return.

Function
REQ-012 SHALL keep registers: owner (address-phase owner), downer plus dvalid (data-phase owner, transfer active), last_win, and per master a holding register hold_x plus hvalid_x capturing address and control.
REQ-013 SHALL define req_x = hvalid_x OR Mx_HTRANS[1]; presented_x = hold_x when hvalid_x else live Mx inputs.
REQ-014 SHALL select sel combinationally: if S_HREADY=0, sel=owner; else if presented_owner has HMASTLOCK=1 or HTRANS in {BUSY,SEQ}, sel=owner; else if both req, sel=NOT last_win; else the single requester; else owner (parked).
REQ-015 SHALL drive S_* address/control from presented_sel, with S_HTRANS forced to IDLE (00) when req_sel=0.
REQ-016 SHALL drive S_HWDATA from Mdowner_HWDATA.
REQ-017 SHALL, on each HCLK edge with S_HREADY=1: owner<=sel; downer<=sel; dvalid<=S_HTRANS[1]; clear hvalid_sel; last_win<=sel when both req and arbitration was not held by lock/burst.
REQ-018 SHALL capture Mx live address/control into hold_x and set hvalid_x when x != sel, Mx_HTRANS[1]=1, Mx_HREADY=1 and hvalid_x=0, independent of S_HREADY.
REQ-019 SHALL drive Mx_HREADY = S_HREADY when dvalid and downer=x; else 0 when hvalid_x; else 1.
REQ-020 SHALL drive Mx_HRESP = S_HRESP when dvalid and downer=x, else 0 (OKAY); two-cycle ERROR passes unchanged.
REQ-021 SHALL add zero latency to an uncontested master; a captured transfer reaches the bus at the first arbitration it wins.
REQ-022 SHALL never switch owner between beats of a burst (SEQ/BUSY) or while HMASTLOCK=1.
REQ-023 SHALL treat simultaneous NONSEQ from both masters on an idle bus as contested (REQ-014 round-robin).

Reset
REQ-024 SHALL, while HRESET=1, set owner=downer=DEFAULT_MASTER, last_win=NOT DEFAULT_MASTER, dvalid=0, hvalid_x=0, giving S_HTRANS=IDLE, Mx_HREADY=1, Mx_HRESP=0.
REQ-025 SHALL discard held and in-flight transfers on reset assertion mid-operation, with no stale issue after release.

Structure
REQ-026 SHALL take HTRANS encodings (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11), HRESP OKAY/ERROR, and the hold-record typedef from shared package ahbl_pkg.
REQ-027 SHALL implement the holding register as sub-module ahbl_hold_stage, instantiated once per master.

Verification
REQ-028 SHALL check uncontested: M0 single write 0x1000/0xA5A5A5A5, zero-wait slave -> S_HTRANS NONSEQ same cycle, M0_HREADY never low.
REQ-029 SHALL check contention: both NONSEQ same cycle after reset (DEFAULT_MASTER=0) -> M0 issued first, M1 held, M1_HREADY low until its bus data phase completes, M1 next.
REQ-030 SHALL check burst: M1 INCR4 read owning the bus, M0 NONSEQ on beat 2 -> four M1 beats contiguous, M0 issued next cycle.
REQ-031 SHALL check lock: M0 HMASTLOCK=1 across two singles, M1 requesting -> no switch until HMASTLOCK drops.
REQ-032 SHALL check error and wait: slave 2 wait states then ERROR on M1 transfer -> M1_HRESP=1 two cycles, M0_HRESP=0 throughout.
REQ-033 SHALL check reset mid-operation: HRESET pulsed with hvalid_1=1 -> S_HTRANS IDLE immediately, held transfer never issued.

Source files
------------

// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and the address/control record that the
// two-master arbiter holds, presents and forwards.
package ahbl_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef struct packed {
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hwrite;
    logic        hmastlock;
  } ahb_ctrl_t;

  // True when the presented transfer forbids rearbitration (burst beat or lock).
  function automatic logic ctrl_holds_bus(input ahb_ctrl_t c);
    return c.hmastlock || (c.htrans == HTRANS_BUSY) || (c.htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahbl_hold_stage.sv
// Per-master holding register: parks an address phase that lost arbitration
// and presents it (instead of the live master signals) until it is issued.
module ahbl_hold_stage
  import ahbl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  ahb_ctrl_t live,
  input  logic      sel_me,
  input  logic      bus_ready,
  input  logic      master_ready,
  output logic      hvalid,
  output ahb_ctrl_t presented,
  output logic      req
);

  ahb_ctrl_t hold;
  logic      capture;
  logic      clear;

  assign capture = !sel_me && live.htrans[1] && master_ready && !hvalid;
  assign clear   = bus_ready && sel_me;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hvalid <= 1'b0;
      hold   <= '0;
    end else if (clear) begin
      hvalid <= 1'b0;
    end else if (capture) begin
      hvalid <= 1'b1;
      hold   <= live;
    end
  end

  assign presented = hvalid ? hold : live;
  assign req       = hvalid | live.htrans[1];

endmodule

// File: rtl/ahbl_arb2.sv
// Two-master AHB-Lite arbiter with round-robin on contention, zero added
// latency for an uncontested master, and no switching inside bursts or locks.
module ahbl_arb2
  import ahbl_pkg::*;
#(
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,

  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic [2:0]  M0_HSIZE,
  input  logic [2:0]  M0_HBURST,
  input  logic [3:0]  M0_HPROT,
  input  logic        M0_HWRITE,
  input  logic        M0_HMASTLOCK,
  input  logic [31:0] M0_HWDATA,
  output logic [31:0] M0_HRDATA,
  output logic        M0_HREADY,
  output logic        M0_HRESP,

  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic [2:0]  M1_HSIZE,
  input  logic [2:0]  M1_HBURST,
  input  logic [3:0]  M1_HPROT,
  input  logic        M1_HWRITE,
  input  logic        M1_HMASTLOCK,
  input  logic [31:0] M1_HWDATA,
  output logic [31:0] M1_HRDATA,
  output logic        M1_HREADY,
  output logic        M1_HRESP,

  output logic [31:0] S_HADDR,
  output logic [1:0]  S_HTRANS,
  output logic [2:0]  S_HSIZE,
  output logic [2:0]  S_HBURST,
  output logic [3:0]  S_HPROT,
  output logic        S_HWRITE,
  output logic        S_HMASTLOCK,
  output logic [31:0] S_HWDATA,
  input  logic [31:0] S_HRDATA,
  input  logic        S_HREADY,
  input  logic        S_HRESP
);

  localparam logic DEF_M = (DEFAULT_MASTER != 0);

  logic      owner, downer, dvalid, last_win;
  logic      sel, req_sel, held_arb;
  logic      req0, req1, hvalid0, hvalid1;
  ahb_ctrl_t live0, live1, pres0, pres1, pres_owner, pres_sel;

  assign live0 = '{haddr: M0_HADDR, htrans: M0_HTRANS, hsize: M0_HSIZE,
                   hburst: M0_HBURST, hprot: M0_HPROT, hwrite: M0_HWRITE,
                   hmastlock: M0_HMASTLOCK};
  assign live1 = '{haddr: M1_HADDR, htrans: M1_HTRANS, hsize: M1_HSIZE,
                   hburst: M1_HBURST, hprot: M1_HPROT, hwrite: M1_HWRITE,
                   hmastlock: M1_HMASTLOCK};

  ahbl_hold_stage u_hold0 (
    .clk          (HCLK),
    .rst          (HRESET),
    .live         (live0),
    .sel_me       (!sel),
    .bus_ready    (S_HREADY),
    .master_ready (M0_HREADY),
    .hvalid       (hvalid0),
    .presented    (pres0),
    .req          (req0)
  );

  ahbl_hold_stage u_hold1 (
    .clk          (HCLK),
    .rst          (HRESET),
    .live         (live1),
    .sel_me       (sel),
    .bus_ready    (S_HREADY),
    .master_ready (M1_HREADY),
    .hvalid       (hvalid1),
    .presented    (pres1),
    .req          (req1)
  );

  assign pres_owner = owner ? pres1 : pres0;
  assign held_arb   = ctrl_holds_bus(pres_owner);

  always_comb begin
    sel = owner;
    if (S_HREADY && !held_arb) begin
      if (req0 && req1) sel = ~last_win;
      else if (req0)    sel = 1'b0;
      else if (req1)    sel = 1'b1;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      owner    <= DEF_M;
      downer   <= DEF_M;
      dvalid   <= 1'b0;
      last_win <= ~DEF_M;
    end else if (S_HREADY) begin
      owner  <= sel;
      downer <= sel;
      dvalid <= S_HTRANS[1];
      if (req0 && req1 && !held_arb) last_win <= sel;
    end
  end

  assign pres_sel = sel ? pres1 : pres0;
  assign req_sel  = sel ? req1  : req0;

  // Reset gates the bus combinationally so it idles the moment HRESET rises.
  assign S_HTRANS    = (req_sel && !HRESET) ? pres_sel.htrans : HTRANS_IDLE;
  assign S_HADDR     = pres_sel.haddr;
  assign S_HSIZE     = pres_sel.hsize;
  assign S_HBURST    = pres_sel.hburst;
  assign S_HPROT     = pres_sel.hprot;
  assign S_HWRITE    = pres_sel.hwrite;
  assign S_HMASTLOCK = pres_sel.hmastlock;
  assign S_HWDATA    = downer ? M1_HWDATA : M0_HWDATA;

  assign M0_HRDATA = S_HRDATA;
  assign M1_HRDATA = S_HRDATA;

  assign M0_HREADY = (dvalid && !downer) ? S_HREADY : !hvalid0;
  assign M1_HREADY = (dvalid &&  downer) ? S_HREADY : !hvalid1;
  assign M0_HRESP  = (dvalid && !downer) ? S_HRESP  : HRESP_OKAY;
  assign M1_HRESP  = (dvalid &&  downer) ? S_HRESP  : HRESP_OKAY;

endmodule

// File: tb/tb_ahbl_arb2.sv
// Directed bench for ahbl_arb2: per-cycle vector table plus hand sequences
// for asynchronous reset and write/read data routing.
module tb_ahbl_arb2;

  localparam logic [1:0] T_ID = 2'b00;
  localparam logic [1:0] T_NS = 2'b10;
  localparam logic [1:0] T_SQ = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic [31:0] M0_HADDR = '0, M1_HADDR = '0;
  logic [1:0]  M0_HTRANS = T_ID, M1_HTRANS = T_ID;
  logic [2:0]  M0_HSIZE = 3'b010, M1_HSIZE = 3'b010;
  logic [2:0]  M0_HBURST = 3'b000, M1_HBURST = 3'b011;
  logic [3:0]  M0_HPROT = 4'b0011, M1_HPROT = 4'b0011;
  logic        M0_HWRITE = 1'b1, M1_HWRITE = 1'b0;
  logic        M0_HMASTLOCK = 1'b0, M1_HMASTLOCK = 1'b0;
  logic [31:0] M0_HWDATA = 32'hA5A5_A5A5, M1_HWDATA = 32'h5A5A_5A5A;
  logic [31:0] M0_HRDATA, M1_HRDATA;
  logic        M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP;
  logic [31:0] S_HADDR, S_HWDATA;
  logic [1:0]  S_HTRANS;
  logic [2:0]  S_HSIZE, S_HBURST;
  logic [3:0]  S_HPROT;
  logic        S_HWRITE, S_HMASTLOCK;
  logic [31:0] S_HRDATA = 32'h1234_5678;
  logic        S_HREADY = 1'b1;
  logic        S_HRESP = 1'b0;

  int nvec = 0;
  int nmis = 0;

  ahbl_arb2 #(.DEFAULT_MASTER(0)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HSIZE(M0_HSIZE),
    .M0_HBURST(M0_HBURST), .M0_HPROT(M0_HPROT), .M0_HWRITE(M0_HWRITE),
    .M0_HMASTLOCK(M0_HMASTLOCK), .M0_HWDATA(M0_HWDATA), .M0_HRDATA(M0_HRDATA),
    .M0_HREADY(M0_HREADY), .M0_HRESP(M0_HRESP),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HSIZE(M1_HSIZE),
    .M1_HBURST(M1_HBURST), .M1_HPROT(M1_HPROT), .M1_HWRITE(M1_HWRITE),
    .M1_HMASTLOCK(M1_HMASTLOCK), .M1_HWDATA(M1_HWDATA), .M1_HRDATA(M1_HRDATA),
    .M1_HREADY(M1_HREADY), .M1_HRESP(M1_HRESP),
    .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HSIZE(S_HSIZE),
    .S_HBURST(S_HBURST), .S_HPROT(S_HPROT), .S_HWRITE(S_HWRITE),
    .S_HMASTLOCK(S_HMASTLOCK), .S_HWDATA(S_HWDATA), .S_HRDATA(S_HRDATA),
    .S_HREADY(S_HREADY), .S_HRESP(S_HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    string       nm;
    logic        rst;
    logic [1:0]  t0;
    logic [31:0] a0;
    logic        l0;
    logic [1:0]  t1;
    logic [31:0] a1;
    logic        srdy;
    logic        sresp;
    logic [1:0]  et;
    logic [31:0] ea;
    logic [3:0]  ef;   // {M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP}
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input string nm, input logic rst,
                              input logic [1:0] t0, input logic [31:0] a0, input logic l0,
                              input logic [1:0] t1, input logic [31:0] a1,
                              input logic srdy, input logic sresp,
                              input logic [1:0] et, input logic [31:0] ea,
                              input logic [3:0] ef);
    vec_t v;
    v.nm = nm; v.rst = rst; v.t0 = t0; v.a0 = a0; v.l0 = l0; v.t1 = t1; v.a1 = a1;
    v.srdy = srdy; v.sresp = sresp; v.et = et; v.ea = ea; v.ef = ef;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    M0_HTRANS = T_ID; M0_HADDR = '0; M0_HMASTLOCK = 1'b0;
    M1_HTRANS = T_ID; M1_HADDR = '0;
    S_HREADY = 1'b1; S_HRESP = 1'b0;
  endtask

  initial begin
    // uncontested single
    vq.push_back(mk("rst_a",          1, T_ID, 0,        0, T_ID, 0,        1, 0, T_ID, 0,        4'b1100));
    vq.push_back(mk("unc_addr",       0, T_NS, 32'h1000, 0, T_ID, 0,        1, 0, T_NS, 32'h1000, 4'b1100));
    vq.push_back(mk("unc_data",       0, T_ID, 0,        0, T_ID, 0,        1, 0, T_ID, 0,        4'b1100));
    // contention after reset, then round-robin
    vq.push_back(mk("rst_b",          1, T_ID, 0,        0, T_ID, 0,        1, 0, T_ID, 0,        4'b1100));
    vq.push_back(mk("cont_m0_first",  0, T_NS, 32'h2000, 0, T_NS, 32'h3000, 1, 0, T_NS, 32'h2000, 4'b1100));
    vq.push_back(mk("cont_m1_issue",  0, T_ID, 0,        0, T_NS, 32'h3000, 1, 0, T_NS, 32'h3000, 4'b1000));
    vq.push_back(mk("cont_m1_wait",   0, T_ID, 0,        0, T_ID, 0,        0, 0, T_ID, 0,        4'b1000));
    vq.push_back(mk("cont_m1_done",   0, T_ID, 0,        0, T_ID, 0,        1, 0, T_ID, 0,        4'b1100));
    vq.push_back(mk("rr_m1_wins",     0, T_NS, 32'h2004, 0, T_NS, 32'h3004, 1, 0, T_NS, 32'h3004, 4'b1100));
    vq.push_back(mk("rr_m0_next",     0, T_NS, 32'h2004, 0, T_ID, 0,        1, 0, T_NS, 32'h2004, 4'b0100));
    vq.push_back(mk("rr_m0_data",     0, T_ID, 0,        0, T_ID, 0,        1, 0, T_ID, 0,        4'b1100));
    // M1 INCR4 read, M0 arrives on beat 2
    vq.push_back(mk("rst_c",          1, T_ID, 0,        0, T_ID, 0,        1, 0, T_ID, 0,        4'b1100));
    vq.push_back(mk("burst_b1",       0, T_ID, 0,        0, T_NS, 32'h4000, 1, 0, T_NS, 32'h4000, 4'b1100));
    vq.push_back(mk("burst_b2",       0, T_NS, 32'h5000, 0, T_SQ, 32'h4004, 1, 0, T_SQ, 32'h4004, 4'b1100));
    vq.push_back(mk("burst_b3",       0, T_NS, 32'h5000, 0, T_SQ, 32'h4008, 1, 0, T_SQ, 32'h4008, 4'b0100));
    vq.push_back(mk("burst_b4",       0, T_NS, 32'h5000, 0, T_SQ, 32'h400C, 1, 0, T_SQ, 32'h400C, 4'b0100));
    vq.push_back(mk("burst_m0_next",  0, T_NS, 32'h5000, 0, T_ID, 0,        1, 0, T_NS, 32'h5000, 4'b0100));
    vq.push_back(mk("burst_m0_data",  0, T_ID, 0,        0, T_ID, 0,        1, 0, T_ID, 0,        4'b1100));
    // lock: M0 wins once (M1 now favoured), then two locked singles
    vq.push_back(mk("rst_d",          1, T_ID, 0,        0, T_ID, 0,        1, 0, T_ID, 0,        4'b1100));
    vq.push_back(mk("lock_pre",       0, T_NS, 32'h6000, 0, T_NS, 32'h7000, 1, 0, T_NS, 32'h6000, 4'b1100));
    vq.push_back(mk("lock_beat1",     0, T_NS, 32'h6004, 1, T_NS, 32'h7000, 1, 0, T_NS, 32'h6004, 4'b1000));
    vq.push_back(mk("lock_beat2",     0, T_NS, 32'h6008, 1, T_NS, 32'h7000, 1, 0, T_NS, 32'h6008, 4'b1000));
    vq.push_back(mk("lock_release",   0, T_ID, 0,        0, T_NS, 32'h7000, 1, 0, T_NS, 32'h7000, 4'b1000));
    vq.push_back(mk("lock_m1_data",   0, T_ID, 0,        0, T_ID, 0,        1, 0, T_ID, 0,        4'b1100));
    // two wait states then two-cycle ERROR on an M1 transfer, M0 queued meanwhile
    vq.push_back(mk("rst_e",          1, T_ID, 0,        0, T_ID, 0,        1, 0, T_ID, 0,        4'b1100));
    vq.push_back(mk("err_m1_addr",    0, T_ID, 0,        0, T_NS, 32'h8000, 1, 0, T_NS, 32'h8000, 4'b1100));
    vq.push_back(mk("err_wait1",      0, T_NS, 32'h9000, 0, T_ID, 0,        0, 0, T_ID, 0,        4'b1000));
    vq.push_back(mk("err_wait2",      0, T_NS, 32'h9000, 0, T_ID, 0,        0, 0, T_ID, 0,        4'b0000));
    vq.push_back(mk("err_cycle1",     0, T_NS, 32'h9000, 0, T_ID, 0,        0, 1, T_ID, 0,        4'b0001));
    vq.push_back(mk("err_cycle2",     0, T_NS, 32'h9000, 0, T_ID, 0,        1, 1, T_NS, 32'h9000, 4'b0101));
    vq.push_back(mk("err_after",      0, T_ID, 0,        0, T_ID, 0,        1, 0, T_ID, 0,        4'b1100));

    foreach (vq[i]) begin
      @(negedge HCLK);
      HRESET = vq[i].rst;
      M0_HTRANS = vq[i].t0; M0_HADDR = vq[i].a0; M0_HMASTLOCK = vq[i].l0;
      M1_HTRANS = vq[i].t1; M1_HADDR = vq[i].a1;
      S_HREADY = vq[i].srdy; S_HRESP = vq[i].sresp;
      #2;
      nvec++;
      if (S_HTRANS !== vq[i].et || (vq[i].et[1] && S_HADDR !== vq[i].ea) ||
          {M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP} !== vq[i].ef) begin
        nmis++;
        $display("FAIL %s: got trans=%b addr=%h rdy/resp=%b want trans=%b addr=%h rdy/resp=%b",
                 vq[i].nm, S_HTRANS, S_HADDR, {M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP},
                 vq[i].et, vq[i].ea, vq[i].ef);
      end
    end

    // reset asserted mid-cycle while M1 is held and M0 is still driving
    @(negedge HCLK); HRESET = 1'b1; drive_idle();
    @(negedge HCLK); HRESET = 1'b0;
    M0_HTRANS = T_NS; M0_HADDR = 32'hA000;
    M1_HTRANS = T_NS; M1_HADDR = 32'hB000;
    @(posedge HCLK); #2;
    chk("rst_pre_m1_held", {31'd0, M1_HREADY}, 32'd0);
    #1 HRESET = 1'b1;
    #1;
    chk("rst_async_trans", {30'd0, S_HTRANS}, {30'd0, T_ID});
    chk("rst_async_m1rdy", {31'd0, M1_HREADY}, 32'd1);
    @(negedge HCLK); drive_idle();
    @(negedge HCLK); HRESET = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge HCLK); #2;
      chk("rst_no_stale_trans", {30'd0, S_HTRANS}, {30'd0, T_ID});
      chk("rst_no_stale_rdy", {30'd0, M0_HREADY, M1_HREADY}, 32'd3);
    end

    // write-data and read-data routing follow the data-phase owner
    @(negedge HCLK); M0_HTRANS = T_NS; M0_HADDR = 32'h1000; #2;
    chk("wr_m0_hwrite", {31'd0, S_HWRITE}, 32'd1);
    @(negedge HCLK); drive_idle(); #2;
    chk("wr_m0_hwdata", S_HWDATA, 32'hA5A5_A5A5);
    chk("rd_m0_hrdata", M0_HRDATA, 32'h1234_5678);
    @(negedge HCLK); M1_HTRANS = T_NS; M1_HADDR = 32'hC000; #2;
    chk("rd_m1_hwrite", {31'd0, S_HWRITE}, 32'd0);
    chk("rd_m1_hburst", {29'd0, S_HBURST}, 32'd3);
    @(negedge HCLK); drive_idle(); S_HRDATA = 32'hCAFE_F00D; #2;
    chk("wr_m1_hwdata", S_HWDATA, 32'h5A5A_5A5A);
    chk("rd_m1_hrdata", M1_HRDATA, 32'hCAFE_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
